// File: rtl/wash_ctrl_multi.sv
// Multi-rinse washing-machine sequencer: door check, fill, detergent, wash, drain,
// RINSE_COUNT rinse rounds, spin. Internal phase timer, pause/resume, fill/drain
// watchdogs and a door-open safety fault. All outputs come straight from flops.
module wash_ctrl_multi #(
  parameter int unsigned TIMER_W       = 16,
  parameter int unsigned RINSE_COUNT   = 2,
  parameter int unsigned WASH_TICKS    = 1000,
  parameter int unsigned RINSE_TICKS   = 500,
  parameter int unsigned SPIN_TICKS    = 300,
  parameter int unsigned FILL_TIMEOUT  = 200,
  parameter int unsigned DRAIN_TIMEOUT = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       close_door,
  input  logic       start,
  input  logic       pause,
  input  logic       fill,
  input  logic       detergent,
  input  logic       drained,
  input  logic       fault_clr,
  output logic       door_lock,
  output logic       motor_on,
  output logic       fill_on,
  output logic       drain_on,
  output logic       detergent_on,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code,
  output logic [2:0] state_o,
  output logic [3:0] rinse_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FILL      = 3'd1,
    S_DETERGENT = 3'd2,
    S_WASH      = 3'd3,
    S_DRAIN     = 3'd4,
    S_SPIN      = 3'd5,
    S_COMPLETE  = 3'd6,
    S_FAULT     = 3'd7
  } state_t;

  localparam logic [TIMER_W-1:0] WASH_LAST  = TIMER_W'(WASH_TICKS - 1);
  localparam logic [TIMER_W-1:0] RINSE_LAST = TIMER_W'(RINSE_TICKS - 1);
  localparam logic [TIMER_W-1:0] SPIN_LAST  = TIMER_W'(SPIN_TICKS - 1);
  localparam logic [TIMER_W-1:0] FILL_LAST  = TIMER_W'(FILL_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] DRAIN_LAST = TIMER_W'(DRAIN_TIMEOUT - 1);
  localparam logic [3:0]         RINSE_MAX  = 4'(RINSE_COUNT);

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [3:0]         drains_q, drains_d;
  logic [1:0]         err_q, err_d;
  logic               seen_q, seen_d;

  logic door_lock_q, door_lock_d;
  logic motor_q, motor_d;
  logic fill_on_q, fill_on_d;
  logic drain_on_q, drain_on_d;
  logic det_on_q, det_on_d;
  logic done_q, done_d;
  logic error_q, error_d;

  logic               in_phase;
  logic               hold;
  logic [TIMER_W-1:0] wash_last;

  // Phase states are the ones where the door is locked and pause applies.
  assign in_phase  = (state_q == S_FILL) || (state_q == S_DETERGENT) ||
                     (state_q == S_WASH) || (state_q == S_DRAIN) || (state_q == S_SPIN);
  assign wash_last = (drains_q == 4'd0) ? WASH_LAST : RINSE_LAST;

  // Next-state: door fault > pause > watchdog > normal phase transition.
  always_comb begin
    state_d  = state_q;
    drains_d = drains_q;
    err_d    = err_q;
    seen_d   = 1'b0;
    hold     = 1'b0;
    if (in_phase && !close_door) begin
      state_d = S_FAULT;
      err_d   = 2'd3;
    end else if (in_phase && pause) begin
      hold = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && close_door) begin
            state_d  = S_FILL;
            drains_d = 4'd0;
          end
        end
        S_FILL: begin
          if (timer_q == FILL_LAST) begin
            state_d = S_FAULT;
            err_d   = 2'd1;
          end else if (fill) begin
            state_d = (drains_q == 4'd0) ? S_DETERGENT : S_WASH;
          end
        end
        S_DETERGENT: begin
          if (detergent) state_d = S_WASH;
        end
        S_WASH: begin
          if (timer_q == wash_last) state_d = S_DRAIN;
        end
        S_DRAIN: begin
          if (timer_q == DRAIN_LAST) begin
            state_d = S_FAULT;
            err_d   = 2'd2;
          end else if (drained) begin
            if (drains_q == RINSE_MAX) begin
              state_d = S_SPIN;
            end else begin
              drains_d = drains_q + 4'd1;
              state_d  = S_FILL;
            end
          end
        end
        S_SPIN: begin
          if (timer_q == SPIN_LAST) state_d = S_COMPLETE;
        end
        S_COMPLETE: begin
          state_d = S_IDLE;
        end
        S_FAULT: begin
          seen_d = seen_q || drained;
          if (drained && fault_clr) begin
            state_d = S_IDLE;
            err_d   = 2'd0;
            seen_d  = 1'b0;
          end
        end
        default: ;
      endcase
    end

    timer_d = timer_q;
    if (state_d != state_q || !in_phase) begin
      timer_d = '0;
    end else if (!hold) begin
      timer_d = timer_q + TIMER_W'(1);
    end
  end

  // Actuator decode of the next state so the output flops track the state register.
  always_comb begin
    door_lock_d = 1'b0;
    motor_d     = 1'b0;
    fill_on_d   = 1'b0;
    drain_on_d  = 1'b0;
    det_on_d    = 1'b0;
    done_d      = 1'b0;
    error_d     = 1'b0;
    case (state_d)
      S_FILL: begin
        door_lock_d = 1'b1;
        fill_on_d   = !hold;
      end
      S_DETERGENT: begin
        door_lock_d = 1'b1;
        det_on_d    = !hold;
      end
      S_WASH: begin
        door_lock_d = 1'b1;
        motor_d     = !hold;
      end
      S_DRAIN: begin
        door_lock_d = 1'b1;
        drain_on_d  = !hold;
      end
      S_SPIN: begin
        door_lock_d = 1'b1;
        motor_d     = !hold;
        drain_on_d  = !hold;
      end
      S_COMPLETE: begin
        done_d = 1'b1;
      end
      S_FAULT: begin
        error_d     = 1'b1;
        drain_on_d  = 1'b1;
        door_lock_d = !seen_d;
      end
      default: ;
    endcase
  end

  // State, timer and programme bookkeeping registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      drains_q <= 4'd0;
      err_q    <= 2'd0;
      seen_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      drains_q <= drains_d;
      err_q    <= err_d;
      seen_q   <= seen_d;
    end
  end

  // Registered actuator and status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      door_lock_q <= 1'b0;
      motor_q     <= 1'b0;
      fill_on_q   <= 1'b0;
      drain_on_q  <= 1'b0;
      det_on_q    <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      door_lock_q <= door_lock_d;
      motor_q     <= motor_d;
      fill_on_q   <= fill_on_d;
      drain_on_q  <= drain_on_d;
      det_on_q    <= det_on_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign door_lock    = door_lock_q;
  assign motor_on     = motor_q;
  assign fill_on      = fill_on_q;
  assign drain_on     = drain_on_q;
  assign detergent_on = det_on_q;
  assign done         = done_q;
  assign error        = error_q;
  assign err_code     = err_q;
  assign state_o      = 3'(state_q);
  assign rinse_o      = drains_q;

endmodule

// File: tb/tb_wash_ctrl_multi.sv
// Directed bench for wash_ctrl_multi: vector tables for full programmes plus
// hand-written pause, watchdog and async-reset sequences.
module tb_wash_ctrl_multi;

  // Inputs packed as {start, close_door, pause, fill, detergent, drained, fault_clr}
  localparam logic [6:0] I_NONE = 7'b0000000;
  localparam logic [6:0] I_SC   = 7'b1100000;
  localparam logic [6:0] I_C    = 7'b0100000;
  localparam logic [6:0] I_CP   = 7'b0110000;
  localparam logic [6:0] I_CF   = 7'b0101000;
  localparam logic [6:0] I_CD   = 7'b0100100;
  localparam logic [6:0] I_CDR  = 7'b0100010;
  localparam logic [6:0] I_CDRC = 7'b0100011;
  localparam logic [6:0] I_DR   = 7'b0000010;
  localparam logic [6:0] I_DRC  = 7'b0000011;

  // Actuators packed as {door_lock, motor_on, fill_on, drain_on, detergent_on, done, error}
  localparam logic [6:0] A_IDLE  = 7'b0000000;
  localparam logic [6:0] A_FILL  = 7'b1010000;
  localparam logic [6:0] A_DET   = 7'b1000100;
  localparam logic [6:0] A_WASH  = 7'b1100000;
  localparam logic [6:0] A_DRAIN = 7'b1001000;
  localparam logic [6:0] A_SPIN  = 7'b1101000;
  localparam logic [6:0] A_CMPL  = 7'b0000010;
  localparam logic [6:0] A_PAUSE = 7'b1000000;
  localparam logic [6:0] A_FLT_L = 7'b1001001;
  localparam logic [6:0] A_FLT_U = 7'b0001001;

  localparam logic [2:0] S_IDLE = 3'd0, S_FILL = 3'd1, S_DET = 3'd2, S_WASH = 3'd3,
                         S_DRAIN = 3'd4, S_SPIN = 3'd5, S_CMPL = 3'd6, S_FAULT = 3'd7;

  typedef struct {
    logic [6:0] in;
    int         n;
    logic [2:0] st;
    logic [6:0] act;
    logic [1:0] ec;
    logic [3:0] rn;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic start, close_door, pause, fill, detergent, drained, fault_clr;

  logic       lock0, mot0, fil0, drn0, det0, done0, err0;
  logic [1:0] ec0;
  logic [2:0] st0;
  logic [3:0] rn0;
  logic       lock1, mot1, fil1, drn1, det1, done1, err1;
  logic [1:0] ec1;
  logic [2:0] st1;
  logic [3:0] rn1;

  int   checks = 0;
  int   failures = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  wash_ctrl_multi #(.TIMER_W(16), .RINSE_COUNT(2), .WASH_TICKS(8), .RINSE_TICKS(4),
                    .SPIN_TICKS(6), .FILL_TIMEOUT(16), .DRAIN_TIMEOUT(16)) dut0 (
    .clk(clk), .reset(reset), .close_door(close_door), .start(start), .pause(pause),
    .fill(fill), .detergent(detergent), .drained(drained), .fault_clr(fault_clr),
    .door_lock(lock0), .motor_on(mot0), .fill_on(fil0), .drain_on(drn0),
    .detergent_on(det0), .done(done0), .error(err0), .err_code(ec0),
    .state_o(st0), .rinse_o(rn0)
  );

  wash_ctrl_multi #(.TIMER_W(16), .RINSE_COUNT(0), .WASH_TICKS(8), .RINSE_TICKS(4),
                    .SPIN_TICKS(6), .FILL_TIMEOUT(16), .DRAIN_TIMEOUT(16)) dut1 (
    .clk(clk), .reset(reset), .close_door(close_door), .start(start), .pause(pause),
    .fill(fill), .detergent(detergent), .drained(drained), .fault_clr(fault_clr),
    .door_lock(lock1), .motor_on(mot1), .fill_on(fil1), .drain_on(drn1),
    .detergent_on(det1), .done(done1), .error(err1), .err_code(ec1),
    .state_o(st1), .rinse_o(rn1)
  );

  function automatic logic [15:0] obs(input int sel);
    if (sel == 0) return {st0, lock0, mot0, fil0, drn0, det0, done0, err0, ec0, rn0};
    return {st1, lock1, mot1, fil1, drn1, det1, done1, err1, ec1, rn1};
  endfunction

  function automatic vec_t mk(input logic [6:0] in, input int n, input logic [2:0] st,
                              input logic [6:0] act, input logic [1:0] ec, input logic [3:0] rn);
    vec_t v;
    v.in = in; v.n = n; v.st = st; v.act = act; v.ec = ec; v.rn = rn;
    return v;
  endfunction

  task automatic set_in(input logic [6:0] v);
    {start, close_door, pause, fill, detergent, drained, fault_clr} = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    set_in(I_NONE);
    reset = 1'b0;
    step();
    step();
    chk("reset_dut0", obs(0), 16'h0);
    chk("reset_dut1", obs(1), 16'h0);
    reset = 1'b1;
    step();
    chk("post_reset_idle", obs(0), 16'h0);
  endtask

  task automatic run_table(input string tname, input int sel);
    for (int r = 0; r < tbl.size(); r++) begin
      set_in(tbl[r].in);
      for (int k = 0; k < tbl[r].n; k++) begin
        step();
        chk($sformatf("%s_row%0d_cyc%0d", tname, r, k), obs(sel),
            {tbl[r].st, tbl[r].act, tbl[r].ec, tbl[r].rn});
      end
    end
  endtask

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int cnt;
    reset = 1'b0;
    set_in(I_NONE);

    // Full programme with two rinse rounds; start held into COMPLETE retriggers.
    do_reset();
    tbl.delete();
    tbl.push_back(mk(I_SC,   1, S_FILL,  A_FILL,  2'd0, 4'd0));
    tbl.push_back(mk(I_C,    2, S_FILL,  A_FILL,  2'd0, 4'd0));
    tbl.push_back(mk(I_CF,   1, S_DET,   A_DET,   2'd0, 4'd0));
    tbl.push_back(mk(I_C,    2, S_DET,   A_DET,   2'd0, 4'd0));
    tbl.push_back(mk(I_CD,   1, S_WASH,  A_WASH,  2'd0, 4'd0));
    tbl.push_back(mk(I_C,    7, S_WASH,  A_WASH,  2'd0, 4'd0));
    tbl.push_back(mk(I_C,    3, S_DRAIN, A_DRAIN, 2'd0, 4'd0));
    tbl.push_back(mk(I_CDR,  1, S_FILL,  A_FILL,  2'd0, 4'd1));
    tbl.push_back(mk(I_C,    2, S_FILL,  A_FILL,  2'd0, 4'd1));
    tbl.push_back(mk(I_CF,   1, S_WASH,  A_WASH,  2'd0, 4'd1));
    tbl.push_back(mk(I_C,    3, S_WASH,  A_WASH,  2'd0, 4'd1));
    tbl.push_back(mk(I_C,    3, S_DRAIN, A_DRAIN, 2'd0, 4'd1));
    tbl.push_back(mk(I_CDR,  1, S_FILL,  A_FILL,  2'd0, 4'd2));
    tbl.push_back(mk(I_C,    2, S_FILL,  A_FILL,  2'd0, 4'd2));
    tbl.push_back(mk(I_CF,   1, S_WASH,  A_WASH,  2'd0, 4'd2));
    tbl.push_back(mk(I_C,    3, S_WASH,  A_WASH,  2'd0, 4'd2));
    tbl.push_back(mk(I_C,    3, S_DRAIN, A_DRAIN, 2'd0, 4'd2));
    tbl.push_back(mk(I_CDR,  1, S_SPIN,  A_SPIN,  2'd0, 4'd2));
    tbl.push_back(mk(I_C,    5, S_SPIN,  A_SPIN,  2'd0, 4'd2));
    tbl.push_back(mk(I_C,    1, S_CMPL,  A_CMPL,  2'd0, 4'd2));
    tbl.push_back(mk(I_SC,   1, S_IDLE,  A_IDLE,  2'd0, 4'd2));
    tbl.push_back(mk(I_SC,   1, S_FILL,  A_FILL,  2'd0, 4'd0));
    run_table("full_prog", 0);

    // No rinse rounds: soap drain goes straight to SPIN; then door opened in SPIN.
    do_reset();
    tbl.delete();
    tbl.push_back(mk(I_SC,   1, S_FILL,  A_FILL,  2'd0, 4'd0));
    tbl.push_back(mk(I_CF,   1, S_DET,   A_DET,   2'd0, 4'd0));
    tbl.push_back(mk(I_CD,   1, S_WASH,  A_WASH,  2'd0, 4'd0));
    tbl.push_back(mk(I_C,    7, S_WASH,  A_WASH,  2'd0, 4'd0));
    tbl.push_back(mk(I_C,    2, S_DRAIN, A_DRAIN, 2'd0, 4'd0));
    tbl.push_back(mk(I_CDR,  1, S_SPIN,  A_SPIN,  2'd0, 4'd0));
    tbl.push_back(mk(I_C,    2, S_SPIN,  A_SPIN,  2'd0, 4'd0));
    tbl.push_back(mk(I_NONE, 3, S_FAULT, A_FLT_L, 2'd3, 4'd0));
    tbl.push_back(mk(I_DR,   1, S_FAULT, A_FLT_U, 2'd3, 4'd0));
    tbl.push_back(mk(I_DRC,  1, S_IDLE,  A_IDLE,  2'd0, 4'd0));
    run_table("rc0_door", 1);

    // Pause for 5 cycles at soap-wash timer 3: WASH stretches to 13 cycles.
    do_reset();
    set_in(I_SC); step();
    set_in(I_CF); step();
    set_in(I_CD); step();
    chk("pause_wash_entry", 16'(st0), 16'(S_WASH));
    cnt = 1;
    set_in(I_C);
    repeat (3) begin step(); cnt++; end
    set_in(I_CP);
    for (int k = 0; k < 5; k++) begin
      step();
      cnt++;
      chk($sformatf("pause_hold%0d", k), 16'({st0, lock0, mot0, fil0, drn0, det0, done0, err0}),
          16'({S_WASH, A_PAUSE}));
    end
    set_in(I_C);
    step();
    cnt++;
    chk("pause_resume", 16'({st0, lock0, mot0, fil0, drn0, det0, done0, err0}),
        16'({S_WASH, A_WASH}));
    for (int g = 0; g < 40 && st0 == S_WASH; g++) begin
      step();
      if (st0 == S_WASH) cnt++;
    end
    chk("pause_wash_len", 16'(cnt), 16'd13);
    chk("pause_then_drain", 16'(st0), 16'(S_DRAIN));

    // Fill watchdog: 16 FILL cycles, then FAULT with code 1; drained + clear recovers.
    do_reset();
    set_in(I_SC); step();
    cnt = 1;
    set_in(I_C);
    for (int g = 0; g < 40 && st0 == S_FILL; g++) begin
      step();
      if (st0 == S_FILL) cnt++;
    end
    chk("fill_to_len", 16'(cnt), 16'd16);
    chk("fill_to_fault", obs(0), {S_FAULT, A_FLT_L, 2'd1, 4'd0});
    set_in(I_CDR); step();
    chk("fill_to_drained", obs(0), {S_FAULT, A_FLT_U, 2'd1, 4'd0});
    set_in(I_CDRC); step();
    chk("fill_to_clear", obs(0), {S_IDLE, A_IDLE, 2'd0, 4'd0});

    // Asynchronous reset in the middle of DRAIN, no resume afterwards.
    do_reset();
    set_in(I_SC); step();
    set_in(I_CF); step();
    set_in(I_CD); step();
    set_in(I_C);
    for (int g = 0; g < 40 && st0 != S_DRAIN; g++) step();
    step();
    chk("arst_in_drain", obs(0), {S_DRAIN, A_DRAIN, 2'd0, 4'd0});
    #3;
    reset = 1'b0;
    #1;
    chk("arst_immediate", obs(0), 16'h0);
    step();
    reset = 1'b1;
    step();
    chk("arst_no_resume", obs(0), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wash_ctrl_multi.md
Name: wash_ctrl_multi

Overview:
Parametrised washing-machine sequencer that replaces the single soap-plus-rinse controller. It runs door check, fill, detergent, wash, drain, then N rinse fill/wash/drain rounds, then spin. Phase durations come from internal timers instead of external timeout strobes. Adds pause/resume, fill/drain watchdogs, a door-open safety fault and a status output for the front-panel block.

Parameters:
TIMER_W, 16, width of the shared phase timer
RINSE_COUNT, 2, number of rinse rounds after the soap wash (0..15)
WASH_TICKS, 1000, clock cycles of motor run in the soap wash (>=1, < 2^TIMER_W)
RINSE_TICKS, 500, clock cycles of motor run per rinse round (>=1)
SPIN_TICKS, 300, clock cycles of spin (>=1)
FILL_TIMEOUT, 200, max cycles in FILL before fault (>=1)
DRAIN_TIMEOUT, 200, max cycles in DRAIN before fault (>=1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
close_door  in  1  door-closed sensor
start  in  1  start request, level-sampled in IDLE
pause  in  1  level; high freezes the running programme
fill  in  1  water-level-reached sensor
detergent  in  1  detergent-dispensed acknowledge
drained  in  1  drum-empty sensor
fault_clr  in  1  fault acknowledge
door_lock  out  1  door lock solenoid
motor_on  out  1  drum motor
fill_on  out  1  inlet valve
drain_on  out  1  drain pump
detergent_on  out  1  detergent dispenser
done  out  1  one-cycle completion pulse
error  out  1  high while in FAULT
err_code  out  2  0 none, 1 fill timeout, 2 drain timeout, 3 door opened while locked
state_o  out  3  current state encoding
rinse_o  out  4  completed drain count (drains_done)

Behaviour:
- States: IDLE=0, FILL=1, DETERGENT=2, WASH=3, DRAIN=4, SPIN=5, COMPLETE=6, FAULT=7.
- Reset (reset=0, async): state IDLE. Timer, drains_done, err_code and the paused flag go to 0. All outputs go to 0.
- Outputs are a Moore decode of the state register plus the paused flag. No input-to-output combinational path.
- Timer: cleared on every state change. Increments once per cycle while running and not paused. Phase of N ticks exits in the cycle where timer==N-1, so the state is held for exactly N cycles.
- IDLE: all outputs 0. When start=1 and close_door=1, go to FILL and clear drains_done.
- FILL: fill_on=1, door_lock=1.
  - fill=1: go to DETERGENT if drains_done==0, else go to WASH.
  - timer==FILL_TIMEOUT-1 without fill: go to FAULT, err_code=1.
- DETERGENT: detergent_on=1, door_lock=1. detergent=1 -> WASH. No timeout.
- WASH: motor_on=1, door_lock=1. Runs WASH_TICKS when drains_done==0, else RINSE_TICKS, then goes to DRAIN.
- DRAIN: drain_on=1, door_lock=1.
  - drained=1 and drains_done==RINSE_COUNT: go to SPIN.
  - drained=1 otherwise: drains_done+1, go to FILL.
  - timeout at DRAIN_TIMEOUT-1: go to FAULT, err_code=2.
  - RINSE_COUNT=0 goes directly from soap drain to SPIN.
- SPIN: motor_on=1, drain_on=1, door_lock=1. After SPIN_TICKS, go to COMPLETE.
- COMPLETE: done=1 and door_lock=0 for exactly one cycle, then IDLE.
- Pause:
  - Applies in FILL, DETERGENT, WASH, DRAIN and SPIN. Ignored in IDLE, COMPLETE and FAULT.
  - While pause=1: state and timer hold, sensor inputs are ignored, and watchdogs do not advance.
  - motor_on, fill_on, drain_on and detergent_on are 0. door_lock stays 1.
  - Resume continues with the remaining ticks.
- Door fault: close_door=0 in any state with door_lock=1 (including while paused) goes to FAULT, err_code=3. This has priority over the same-cycle phase exit.
- FAULT:
  - error=1, drain_on=1 (safety drain), other actuators 0.
  - door_lock=1 until drained=1 is seen, then 0.
  - drained=1 and fault_clr=1 in the same cycle: go to IDLE and clear err_code.
- Priority per cycle: reset > door fault > pause > watchdog timeout > normal transition.
- Reset mid-programme aborts immediately to IDLE with all actuators off. No resume.
- start held high through COMPLETE re-triggers a new programme from IDLE one cycle later.

Test Plan:
- Params WASH=8, RINSE=4, SPIN=6, RINSE_COUNT=2, timeouts=16. start+close_door, then fill/detergent/drained each after 3 cycles. Required: state sequence 1,2,3,4,1,3,4,1,3,4,5,6,0; WASH held 8 cycles per soap wash and 4 per rinse; done high for exactly 1 cycle; rinse_o ends at 2.
- RINSE_COUNT=0: first drained in DRAIN -> SPIN directly; rinse_o stays 0.
- pause=1 for 5 cycles at soap-wash timer=3: motor_on=0 and door_lock=1 during pause; WASH lasts 13 cycles total.
- fill never asserted: at the 16th FILL cycle, state 7 with err_code=1 and drain_on=1; drained + fault_clr -> IDLE with err_code=0.
- close_door drops in SPIN: next cycle state 7 with err_code=3 and motor_on=0; door_lock=1 until drained=1.
- reset pulsed low in the middle of DRAIN, asynchronously off the clock edge: all outputs 0 immediately and state_o=0.
